inst_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the IF stage's instruction memory.
- Accepts a byte stream (valid/ready) carrying a 16-bit word count followed by little-endian 32-bit instructions.
- Packs the bytes into words and writes them sequentially into instruction memory from address 0.
- Holds the core in reset (core_run low) until the load completes.

---
 rtl/inst_loader_pkg.sv | 24 ++
 rtl/inst_loader_byte_packer.sv | 33 +++
 rtl/inst_loader.sv | 161 ++++++++++++++++
 tb/tb_inst_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// The CSUM state exists only when INST_LOADER_CHECKSUM_EN is defined.
package inst_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DONE,
    S_ERROR
`ifdef INST_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_e;

  function automatic int max_words(input int mem_bytes);
    return mem_bytes / BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid_o flags the byte
// that completes a word, with word_o holding the full word in that same cycle.
module inst_loader_byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [23:0] sr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (byte_valid_i) begin
      cnt_q <= cnt_q + 2'd1;
      // Newest byte enters at the top so the first byte ends up in [7:0].
      sr_q  <= {byte_i, sr_q[23:8]};
    end
  end

  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
  assign word_o       = {byte_i, sr_q};

endmodule

// File: rtl/inst_loader.sv
// Boot loader: length-prefixed byte stream -> sequential instruction memory writes.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int PC_SIZE       = 32,
  parameter int INST_MEM_SIZE = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               mem_we,
  output logic [PC_SIZE-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               core_run,
  output logic               busy,
  output logic               error,
  output logic [LEN_W-1:0]   words_loaded
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   words_loaded_q;
  logic               mem_we_q;
  logic [PC_SIZE-1:0] mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               core_run_q;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  logic             accept;
  logic             start_ok;
  logic [LEN_W-1:0] len_full;
  logic             last_word;
  logic             word_valid;
  logic [31:0]      word;

  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign len_full  = {rx_data, len_q[7:0]};
  assign last_word = ((words_loaded_q + 16'd1) == len_q);

  inst_loader_byte_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (start_ok),
    .byte_valid_i (accept && (state_q == S_DATA)),
    .byte_i       (rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_full == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if ({16'd0, len_full} > 32'(max_words(INST_MEM_SIZE))) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_valid && last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q          <= '0;
      words_loaded_q <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      core_run_q     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      mem_we_q <= word_valid;
      if (start_ok) begin
        len_q          <= '0;
        words_loaded_q <= '0;
        core_run_q     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_q         <= '0;
`endif
      end else begin
        if (accept && state_q == S_LEN_LO) len_q[7:0]  <= rx_data;
        if (accept && state_q == S_LEN_HI) len_q[15:8] <= rx_data;
        // Address is captured from the pre-increment count in the same edge.
        if (word_valid) begin
          mem_addr_q     <= PC_SIZE'({words_loaded_q, 2'b00});
          mem_wdata_q    <= word;
          words_loaded_q <= words_loaded_q + 16'd1;
        end
`ifdef INST_LOADER_CHECKSUM_EN
        if (accept && state_q == S_DATA) csum_q <= csum_q ^ rx_data;
`endif
        core_run_q <= (state_q == S_DONE);
      end
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_run     = core_run_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a write scoreboard; honours INST_LOADER_CHECKSUM_EN.
module tb_inst_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, core_run, busy, error;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t         sb[$];
  logic [31:0] prog[$];

  inst_loader #(.PC_SIZE(32), .INST_MEM_SIZE(1024)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_run     (core_run),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    wr_t e;
    if (reset && mem_we) begin
      chk("write_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("write_addr", mem_addr, e.addr);
        chk("write_data", mem_wdata, e.data);
        $display("write addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic load_stream(input int nwords, input int min_gap, input int max_gap,
                             input bit bad_csum, input bit start_mid);
    logic [15:0] len16;
    logic [31:0] wd;
    logic [7:0]  b8;
    logic [7:0]  x;
    int          n;
    len16 = 16'(nwords);
    x     = 8'h00;
    pulse_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_error_clr", {31'd0, error}, 32'd0);
    chk("start_run_clr", {31'd0, core_run}, 32'd0);
    chk("start_words_clr", {16'd0, words_loaded}, 32'd0);
    send_byte(len16[7:0], $urandom_range(min_gap, max_gap));
    send_byte(len16[15:8], $urandom_range(min_gap, max_gap));
    for (int w = 0; w < nwords; w++) begin
      wd = prog[w];
      sb.push_back('{addr: 32'(w * 4), data: wd});
      for (int b = 0; b < 4; b++) begin
        b8 = wd[8*b +: 8];
        x  = x ^ b8;
        send_byte(b8, $urandom_range(min_gap, max_gap));
        if (start_mid && w == 0 && b == 1) pulse_start();
      end
    end
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, 0);
    n = 0;
    while (!core_run && !error && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("end_core_run", {31'd0, core_run}, {31'd0, !bad_csum});
    chk("end_error", {31'd0, error}, {31'd0, bad_csum});
`else
    n = 0;
    chk("last_cycle_we", {31'd0, mem_we}, {31'd0, nwords > 0});
    chk("last_cycle_run", {31'd0, core_run}, 32'd0);
    @(negedge clock);
    chk("run_after_last", {31'd0, core_run}, 32'd1);
    chk("end_error", {31'd0, error}, 32'd0);
`endif
    chk("end_words", {16'd0, words_loaded}, 32'(nwords));
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("load words=%0d core_run=%0b error=%0b", nwords, core_run, error);
  endtask

  task automatic set_base_prog();
    prog.delete();
    prog.push_back(32'h0000_0013);
    prog.push_back(32'h0010_0093);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    logic [7:0]  b8;
    repeat (3) @(negedge clock);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_core_run", {31'd0, core_run}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Bytes offered while idle must be ignored.
    rx_data = 8'h55; rx_valid = 1'b1;
    repeat (3) @(negedge clock);
    rx_valid = 1'b0;
    chk("idle_ignore_busy", {31'd0, busy}, 32'd0);
    chk("idle_ignore_words", {16'd0, words_loaded}, 32'd0);

    set_base_prog();
    load_stream(2, 0, 0, 1'b0, 1'b0);

    prog.delete();
    load_stream(0, 0, 0, 1'b0, 1'b0);

    // Oversized length is rejected without writes and stays in error.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("len_err_error", {31'd0, error}, 32'd1);
    chk("len_err_ready", {31'd0, rx_ready}, 32'd0);
    chk("len_err_run", {31'd0, core_run}, 32'd0);
    repeat (3) @(negedge clock);
    chk("len_err_sticky", {31'd0, error}, 32'd1);
    $display("length 257 error=%0b", error);
    set_base_prog();
    load_stream(2, 0, 0, 1'b0, 1'b0);

    // Random 1-3 cycle gaps, plus a start pulse mid-load that must be ignored.
    load_stream(2, 1, 3, 1'b0, 1'b1);

    // Largest legal image.
    prog.delete();
    for (int i = 0; i < 256; i++) prog.push_back($urandom);
    load_stream(256, 0, 0, 1'b0, 1'b0);

    // Abort mid-load after 6 and 7 bytes, then reload from scratch.
    set_base_prog();
    for (int ab = 6; ab <= 7; ab++) begin
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      sb.push_back('{addr: 32'd0, data: prog[0]});
      for (int k = 0; k < ab - 2; k++) begin
        wd = prog[k / 4];
        b8 = wd[8*(k % 4) +: 8];
        send_byte(b8, 0);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("abort_run", {31'd0, core_run}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ready", {31'd0, rx_ready}, 32'd0);
      chk("abort_words", {16'd0, words_loaded}, 32'd0);
      chk("abort_sb", 32'(sb.size()), 32'd0);
      $display("abort after %0d bytes", ab);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      load_stream(2, 0, 0, 1'b0, 1'b0);
    end

`ifdef INST_LOADER_CHECKSUM_EN
    // Bad checksum: writes still happen but the core stays held.
    set_base_prog();
    load_stream(2, 0, 0, 1'b1, 1'b0);
    load_stream(2, 0, 0, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
